// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR pattern generator and its checker:
//   - LFSR width, feedback tap mask and output corruption mask
//   - generator FSM state encoding
//   - lfsr_next(): 8-bit, 256-state next-state function (includes 8'h00)
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int                LFSR_W   = 8;
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'h62;
  localparam logic [LFSR_W-1:0] ERR_MASK = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fsm_state_e;

  // Shift left with feedback f into bit 0, then fold f into taps 1, 5 and 6.
  // f carries an extra term (low seven bits all zero) so that the all-zero
  // state is part of the cycle: 8'h80 -> 8'h00 -> 8'h63.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic f_s;
    f_s = s[7] ^ (s[6:0] == 7'd0);
    return {s[6:0], f_s} ^ (f_s ? TAP_MASK : {LFSR_W{1'b0}});
  endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Combinational LFSR next-state block; the same block is used by the checker
// so generator and checker always agree on the polynomial.
// Ports:
//   state      in  LFSR_W  current LFSR state
//   next_state out LFSR_W  state after one step
// -----------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state
);

  // Next-state evaluation.
  always_comb begin
    next_state = lfsr_next(state);
  end

endmodule : lfsr_step

// File: rtl/lfsr_generator.sv
// -----------------------------------------------------------------------------
// lfsr_generator
// Paced LFSR pattern source feeding the LFSR checker. Emits one word every
// i_rate+1 cycles while enabled, supports seed loading and flags every 256th
// word since start/seed load.
//
// Build option: define LFSR_ERR_INJ_EN to include the error-burst injector
// (ERR state, burst counter, bit-7 output corruption). Without it the inject
// inputs are ignored and o_err_active is constant 0.
//
// Ports:
//   clk           in   1       rising-edge clock
//   i_rst_n       in   1       asynchronous active-low reset
//   i_enable      in   1       level, runs the generator
//   i_seed_load   in   1       pulse, loads i_seed (highest priority)
//   i_seed        in   8       seed value (8'h00 legal)
//   i_rate        in   RATE_W  word spacing minus 1
//   i_err_inject  in   1       pulse, requests a corruption burst
//   i_err_len     in   2       burst length minus 1
//   o_valid       out  1       word strobe
//   o_LFSR        out  8       emitted word
//   o_wrap        out  1       256th word marker (only with o_valid)
//   o_err_active  out  1       burst pending or in progress
// -----------------------------------------------------------------------------
module lfsr_generator
  import lfsr_pkg::*;
#(
  parameter int                RATE_W       = 4,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 8'h01
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_err_inject,
  input  logic [1:0]        i_err_len,
  output logic              o_valid,
  output logic [LFSR_W-1:0] o_LFSR,
  output logic              o_wrap,
  output logic              o_err_active
);

  localparam logic [RATE_W-1:0] RATE_ZERO = {RATE_W{1'b0}};
  localparam logic [RATE_W-1:0] RATE_ONE  = {{(RATE_W-1){1'b0}}, 1'b1};

  fsm_state_e        fsm_r;
  logic [LFSR_W-1:0] state_r;
  logic [LFSR_W-1:0] next_state_s;
  logic [RATE_W-1:0] rate_r;
  logic [RATE_W-1:0] rate_cnt_r;
  logic [7:0]        word_cnt_r;
  logic              valid_r;
  logic              wrap_r;
  logic [LFSR_W-1:0] lfsr_out_r;
  logic              emit_s;

`ifdef LFSR_ERR_INJ_EN
  logic [1:0]        burst_cnt_r;
  logic              err_active_r;
`else
  logic              unused_err_s;
`endif

  lfsr_step u_lfsr_step (
    .state      (state_r),
    .next_state (next_state_s)
  );

  // Rate counter expiry marks an emit cycle while in RUN/ERR.
  always_comb begin
    emit_s = (rate_cnt_r == RATE_ZERO);
  end

  // Sequencer: FSM, rate pacing, LFSR advance, word counter, burst and outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_r        <= IDLE;
      state_r      <= SEED_DEFAULT;
      rate_r       <= RATE_ZERO;
      rate_cnt_r   <= RATE_ZERO;
      word_cnt_r   <= 8'd0;
      valid_r      <= 1'b0;
      wrap_r       <= 1'b0;
      lfsr_out_r   <= {LFSR_W{1'b0}};
`ifdef LFSR_ERR_INJ_EN
      burst_cnt_r  <= 2'd0;
      err_active_r <= 1'b0;
`endif
    end else if (i_seed_load) begin
      // Seed load overrides everything, cancels any burst, emits nothing.
      state_r      <= i_seed;
      word_cnt_r   <= 8'd0;
      rate_r       <= i_rate;
      rate_cnt_r   <= i_rate;
      valid_r      <= 1'b0;
      wrap_r       <= 1'b0;
      fsm_r        <= i_enable ? RUN : IDLE;
`ifdef LFSR_ERR_INJ_EN
      burst_cnt_r  <= 2'd0;
      err_active_r <= 1'b0;
`endif
    end else begin
      valid_r      <= 1'b0;
      wrap_r       <= 1'b0;
`ifdef LFSR_ERR_INJ_EN
      err_active_r <= 1'b0;
`endif
      case (fsm_r)
        IDLE: begin
          // LFSR state is held here so the sequence resumes seamlessly.
          if (i_enable) begin
            fsm_r      <= RUN;
            rate_r     <= i_rate;
            rate_cnt_r <= i_rate;
          end else begin
            fsm_r      <= IDLE;
          end
        end

        RUN: begin
          if (!i_enable) begin
            fsm_r <= IDLE;
          end else begin
            if (emit_s) begin
              valid_r    <= 1'b1;
              lfsr_out_r <= state_r;
              state_r    <= next_state_s;
              wrap_r     <= (word_cnt_r == 8'hFF);
              word_cnt_r <= word_cnt_r + 8'd1;
              rate_cnt_r <= rate_r;
            end else begin
              rate_cnt_r <= rate_cnt_r - RATE_ONE;
            end
`ifdef LFSR_ERR_INJ_EN
            // A request on an emit cycle leaves that word clean; corruption
            // starts with the following word.
            if (i_err_inject) begin
              fsm_r        <= ERR;
              burst_cnt_r  <= i_err_len;
              err_active_r <= 1'b1;
            end else begin
              fsm_r        <= RUN;
            end
`else
            fsm_r <= RUN;
`endif
          end
        end

`ifdef LFSR_ERR_INJ_EN
        ERR: begin
          if (!i_enable) begin
            fsm_r       <= IDLE;
            burst_cnt_r <= 2'd0;
          end else begin
            // Stays high through the cycle of the last corrupted o_valid.
            err_active_r <= 1'b1;
            if (emit_s) begin
              valid_r    <= 1'b1;
              lfsr_out_r <= state_r ^ ERR_MASK;
              state_r    <= next_state_s;
              wrap_r     <= (word_cnt_r == 8'hFF);
              word_cnt_r <= word_cnt_r + 8'd1;
              rate_cnt_r <= rate_r;
              if (burst_cnt_r == 2'd0) begin
                fsm_r       <= RUN;
              end else begin
                fsm_r       <= ERR;
                burst_cnt_r <= burst_cnt_r - 2'd1;
              end
            end else begin
              rate_cnt_r <= rate_cnt_r - RATE_ONE;
              fsm_r      <= ERR;
            end
          end
        end
`endif

        default: begin
          fsm_r <= IDLE;
        end
      endcase
    end
  end

  assign o_valid = valid_r;
  assign o_LFSR  = lfsr_out_r;
  assign o_wrap  = wrap_r;

`ifdef LFSR_ERR_INJ_EN
  assign o_err_active = err_active_r;
`else
  assign o_err_active = 1'b0;
  assign unused_err_s = ^{i_err_inject, i_err_len};
`endif

endmodule : lfsr_generator

// File: tb/tb_lfsr_generator.sv
// -----------------------------------------------------------------------------
// tb_lfsr_generator
// Directed self-checking bench for lfsr_generator. Outputs are sampled on the
// falling clock edge; inputs are also changed there.
// -----------------------------------------------------------------------------
module tb_lfsr_generator;

  logic       clk;
  logic       i_rst_n;
  logic       i_enable;
  logic       i_seed_load;
  logic [7:0] i_seed;
  logic [3:0] i_rate;
  logic       i_err_inject;
  logic [1:0] i_err_len;
  logic       o_valid;
  logic [7:0] o_LFSR;
  logic       o_wrap;
  logic       o_err_active;

  int         checks;
  int         failures;
  logic [7:0] gs;
  logic [7:0] exp_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h00, 8'h63};

  lfsr_generator dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_seed_load  (i_seed_load),
    .i_seed       (i_seed),
    .i_rate       (i_rate),
    .i_err_inject (i_err_inject),
    .i_err_len    (i_err_len),
    .o_valid      (o_valid),
    .o_LFSR       (o_LFSR),
    .o_wrap       (o_wrap),
    .o_err_active (o_err_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden next-state written bit by bit from the polynomial equations.
  function automatic logic [7:0] gnext(input logic [7:0] s);
    logic       f;
    logic [7:0] n;
    f    = s[7] ^ (s[6:0] == 7'd0);
    n[0] = f;
    n[1] = s[0] ^ f;
    n[2] = s[1];
    n[3] = s[2];
    n[4] = s[3];
    n[5] = s[4] ^ f;
    n[6] = s[5] ^ f;
    n[7] = s[6];
    return n;
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0; i_enable = 1'b0; i_seed_load = 1'b0; i_seed = 8'h00;
    i_rate = 4'd0; i_err_inject = 1'b0; i_err_len = 2'd0;
    repeat (3) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_LFSR !== 8'h00) begin failures++; $display("FAIL reset_lfsr got=%h exp=00", o_LFSR); end
    checks++; if (o_wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", o_wrap); end
    checks++; if (o_err_active !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_err_active); end
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", o_valid); end
  endtask

  task automatic test_rate0();
    i_rate = 4'd0;
    i_enable = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rate0_latency valid got=%b exp=0", o_valid); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({o_valid, o_LFSR} !== {1'b1, exp_tbl[i]}) begin
        failures++; $display("FAIL rate0_word%0d got v=%b %h exp v=1 %h", i, o_valid, o_LFSR, exp_tbl[i]);
      end
    end
    gs = gnext(exp_tbl[9]);
    i_enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rate0_stop valid got=%b exp=0", o_valid); end
    end
  endtask

  task automatic test_rate3_pause();
    logic exp_v;
    i_rate = 4'd3;
    i_enable = 1'b1;
    // Valid expected at cycles 5, 9, 13 after enable; drop enable at 15.
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      exp_v = (c >= 5) && (((c - 5) % 4) == 0);
      checks++; if (o_valid !== exp_v) begin failures++; $display("FAIL rate3_valid c=%0d got=%b exp=%b", c, o_valid, exp_v); end
      if (exp_v) begin
        checks++; if (o_LFSR !== gs) begin failures++; $display("FAIL rate3_word c=%0d got=%h exp=%h", c, o_LFSR, gs); end
        gs = gnext(gs);
      end
    end
    i_enable = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL pause_valid c=%0d got=%b exp=0", c, o_valid); end
    end
    i_enable = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_v = (c >= 5) && (((c - 5) % 4) == 0);
      checks++; if (o_valid !== exp_v) begin failures++; $display("FAIL resume_valid c=%0d got=%b exp=%b", c, o_valid, exp_v); end
      if (exp_v) begin
        checks++; if (o_LFSR !== gs) begin failures++; $display("FAIL resume_word c=%0d got=%h exp=%h", c, o_LFSR, gs); end
        gs = gnext(gs);
      end
    end
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_seed_wrap();
    logic exp_w;
    i_rate = 4'd0;
    i_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({o_valid, o_LFSR} !== {1'b1, gs}) begin failures++; $display("FAIL seed_pre got v=%b %h exp v=1 %h", o_valid, o_LFSR, gs); end
    i_seed_load = 1'b1;
    i_seed = 8'h00;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL seed_no_valid got=%b exp=0", o_valid); end
    i_seed_load = 1'b0;
    gs = 8'h00;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      exp_w = (k == 256);
      checks++; if ({o_valid, o_LFSR} !== {1'b1, gs}) begin failures++; $display("FAIL seed_word k=%0d got v=%b %h exp v=1 %h", k, o_valid, o_LFSR, gs); end
      checks++; if (o_wrap !== exp_w) begin failures++; $display("FAIL seed_wrap k=%0d got=%b exp=%b", k, o_wrap, exp_w); end
      if (k == 2) begin
        checks++; if (o_LFSR !== 8'h63) begin failures++; $display("FAIL seed_second got=%h exp=63", o_LFSR); end
      end
      if (k == 256) begin
        checks++; if (o_LFSR !== 8'h80) begin failures++; $display("FAIL seed_256th got=%h exp=80", o_LFSR); end
      end
      if (k == 257) begin
        checks++; if (o_LFSR !== 8'h00) begin failures++; $display("FAIL seed_after_wrap got=%h exp=00", o_LFSR); end
      end
      gs = gnext(gs);
    end
  endtask

`ifdef LFSR_ERR_INJ_EN
  task automatic test_err_burst();
    i_err_inject = 1'b1;
    i_err_len = 2'd3;
    @(negedge clk);
    checks++; if ({o_valid, o_LFSR} !== {1'b1, gs}) begin failures++; $display("FAIL burst_clean0 got v=%b %h exp v=1 %h", o_valid, o_LFSR, gs); end
    checks++; if (o_err_active !== 1'b1) begin failures++; $display("FAIL burst_active0 got=%b exp=1", o_err_active); end
    gs = gnext(gs);
    i_err_inject = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if ({o_valid, o_LFSR} !== {1'b1, gs ^ 8'h80}) begin failures++; $display("FAIL burst_word k=%0d got v=%b %h exp v=1 %h", k, o_valid, o_LFSR, gs ^ 8'h80); end
      checks++; if (o_err_active !== 1'b1) begin failures++; $display("FAIL burst_active k=%0d got=%b exp=1", k, o_err_active); end
      gs = gnext(gs);
      // Second request while in ERR must be ignored.
      i_err_inject = (k == 1);
      i_err_len = 2'd0;
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if ({o_valid, o_LFSR} !== {1'b1, gs}) begin failures++; $display("FAIL burst_after k=%0d got v=%b %h exp v=1 %h", k, o_valid, o_LFSR, gs); end
      checks++; if (o_err_active !== 1'b0) begin failures++; $display("FAIL burst_done k=%0d got=%b exp=0", k, o_err_active); end
      gs = gnext(gs);
    end
  endtask

  task automatic test_err_idle_ignored();
    i_enable = 1'b0;
    @(negedge clk);
    i_err_inject = 1'b1;
    i_err_len = 2'd3;
    @(negedge clk);
    checks++; if ({o_valid, o_err_active} !== 2'b00) begin failures++; $display("FAIL idle_inject got v=%b e=%b exp 0 0", o_valid, o_err_active); end
    i_err_inject = 1'b0;
    i_enable = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if ({o_valid, o_LFSR, o_err_active} !== {1'b1, gs, 1'b0}) begin failures++; $display("FAIL idle_inject_word k=%0d got v=%b %h e=%b exp v=1 %h e=0", k, o_valid, o_LFSR, o_err_active, gs); end
      gs = gnext(gs);
    end
  endtask

  task automatic test_seed_mid_burst();
    i_err_inject = 1'b1;
    i_err_len = 2'd3;
    @(negedge clk);
    checks++; if (o_LFSR !== gs) begin failures++; $display("FAIL mid_clean got=%h exp=%h", o_LFSR, gs); end
    gs = gnext(gs);
    i_err_inject = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if (o_LFSR !== (gs ^ 8'h80)) begin failures++; $display("FAIL mid_corrupt k=%0d got=%h exp=%h", k, o_LFSR, gs ^ 8'h80); end
      gs = gnext(gs);
    end
    i_seed_load = 1'b1;
    i_seed = 8'h5A;
    @(negedge clk);
    checks++; if ({o_valid, o_err_active} !== 2'b00) begin failures++; $display("FAIL mid_seed got v=%b e=%b exp 0 0", o_valid, o_err_active); end
    i_seed_load = 1'b0;
    gs = 8'h5A;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if ({o_valid, o_LFSR, o_err_active} !== {1'b1, gs, 1'b0}) begin failures++; $display("FAIL mid_after k=%0d got v=%b %h e=%b exp v=1 %h e=0", k, o_valid, o_LFSR, o_err_active, gs); end
      gs = gnext(gs);
    end
  endtask
`else
  task automatic test_inject_disabled();
    i_err_inject = 1'b1;
    i_err_len = 2'd3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++; if ({o_valid, o_LFSR, o_err_active} !== {1'b1, gs, 1'b0}) begin failures++; $display("FAIL noinj_word k=%0d got v=%b %h e=%b exp v=1 %h e=0", k, o_valid, o_LFSR, o_err_active, gs); end
      gs = gnext(gs);
      i_err_inject = 1'b0;
    end
  endtask
`endif

  task automatic test_async_reset();
`ifdef LFSR_ERR_INJ_EN
    i_err_inject = 1'b1;
    i_err_len = 2'd3;
    @(negedge clk);
    i_err_inject = 1'b0;
    @(negedge clk);
`else
    @(negedge clk);
`endif
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_valid, o_LFSR, o_wrap, o_err_active} !== 11'h000) begin
      failures++; $display("FAIL async_reset got v=%b %h w=%b e=%b exp all 0", o_valid, o_LFSR, o_wrap, o_err_active);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_restart_latency got=%b exp=0", o_valid); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({o_valid, o_LFSR, o_err_active} !== {1'b1, exp_tbl[k], 1'b0}) begin failures++; $display("FAIL rst_restart k=%0d got v=%b %h e=%b exp v=1 %h e=0", k, o_valid, o_LFSR, o_err_active, exp_tbl[k]); end
    end
    i_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    gs = 8'h01;
    test_reset();
    test_rate0();
    test_rate3_pause();
    test_seed_wrap();
`ifdef LFSR_ERR_INJ_EN
    test_err_burst();
    test_err_idle_ignored();
    test_seed_mid_burst();
`else
    test_inject_disabled();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lfsr_generator
